// File: rtl/mas_alu_seq_exec.sv
// Sequential ALU: one command in flight, shifts executed one bit per cycle.
// IDLE accepts a command, EXEC iterates shifts then finalises, DONE holds the
// registered response until the consumer takes it.
module mas_alu_seq_exec #(
    parameter int unsigned BLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_cmd,
    input  logic [BLEN-1:0] req_op1,
    input  logic [BLEN-1:0] req_op2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BLEN-1:0] rsp_res,
    output logic            rsp_carry,
    output logic            rsp_err,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(BLEN);

    // One-hot state encoding
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_EXEC = 3'b010;
    localparam logic [2:0] ST_DONE = 3'b100;

    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_SRL = 3'd2;
    localparam logic [2:0] CMD_SLL = 3'd3;
    localparam logic [2:0] CMD_SRA = 3'd4;
    localparam logic [2:0] CMD_XOR = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [BLEN-1:0] op1_q, op1_d;     // doubles as the shift working register
    logic [BLEN-1:0] op2_q, op2_d;
    logic [SHW-1:0]  count_q, count_d;
    logic [BLEN-1:0] res_q, res_d;
    logic            carry_q, carry_d;
    logic            err_q, err_d;

    logic [BLEN:0]   sum;
    logic [BLEN:0]   diff;
    logic            req_is_shift;

    // Wide add/subtract; bit BLEN is the carry-out or the borrow
    always_comb begin
        sum  = {1'b0, op1_q} + {1'b0, op2_q};
        diff = {1'b0, op1_q} - {1'b0, op2_q};
        req_is_shift = (req_cmd == CMD_SRL) || (req_cmd == CMD_SLL) || (req_cmd == CMD_SRA);
    end

    // Next-state, operand capture, shift iteration and result finalisation
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        count_d = count_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    cmd_d   = req_cmd;
                    op1_d   = req_op1;
                    op2_d   = req_op2;
                    count_d = req_is_shift ? req_op2[SHW-1:0] : '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (count_q != '0) begin
                    count_d = count_q - SHW'(1);
                    case (cmd_q)
                        CMD_SRL: op1_d = {1'b0, op1_q[BLEN-1:1]};
                        CMD_SLL: op1_d = {op1_q[BLEN-2:0], 1'b0};
                        CMD_SRA: op1_d = {op1_q[BLEN-1], op1_q[BLEN-1:1]};
                        default: op1_d = op1_q;
                    endcase
                end else begin
                    res_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    case (cmd_q)
                        CMD_ADD: begin
                            res_d   = sum[BLEN-1:0];
                            carry_d = sum[BLEN];
                        end
                        CMD_SUB: begin
                            res_d   = diff[BLEN-1:0];
                            carry_d = diff[BLEN];
                        end
                        CMD_SRL, CMD_SLL, CMD_SRA: res_d = op1_q;
                        CMD_XOR: res_d = op1_q ^ op2_q;
                        default: err_d = 1'b1;
                    endcase
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            count_q <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            count_q <= count_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held
    assign req_ready = (state_q == ST_IDLE) && rst_n;
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_res   = res_q;
    assign rsp_carry = carry_q;
    assign rsp_err   = err_q;

`ifndef SYNTHESIS
    a_cmd_known: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && req_ready) |-> !$isunknown(req_cmd))
        else $error("req_cmd unknown at accept");

    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=>
            ($stable(rsp_res) && $stable(rsp_carry) && $stable(rsp_err)))
        else $error("rsp_* changed under backpressure");
`endif

endmodule

// File: tb/tb_mas_alu_seq_exec.sv
// Scoreboard bench for mas_alu_seq_exec: the driver pushes expected responses,
// a monitor pops and compares each response (value and latency) as it appears.
module tb_mas_alu_seq_exec;

    localparam int unsigned BLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_cmd = 3'd0;
    logic [BLEN-1:0] req_op1 = '0;
    logic [BLEN-1:0] req_op2 = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [BLEN-1:0] rsp_res;
    logic            rsp_carry;
    logic            rsp_err;
    logic            busy;

    mas_alu_seq_exec #(.BLEN(BLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BLEN-1:0] res;
        logic            carry;
        logic            err;
        int              lat;
        int              acc;
        string           name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare each rising rsp_valid against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_res"}, 64'(rsp_res), 64'(e.res));
                chk({e.name, "_carry"}, 64'(rsp_carry), 64'(e.carry));
                chk({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
                chk({e.name, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end
        prev_valid <= rsp_valid;
    end

    task automatic issue(input string nm, input logic [2:0] cmd, input logic [BLEN-1:0] a,
                         input logic [BLEN-1:0] b, input logic [BLEN-1:0] res,
                         input logic c, input logic e, input int lat);
        exp_t x;
        @(negedge clk);
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
        if (!req_ready) begin
            chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
        end else begin
            req_valid = 1'b1;
            req_cmd   = cmd;
            req_op1   = a;
            req_op2   = b;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            x.res = res; x.carry = c; x.err = e; x.lat = lat; x.acc = cyc; x.name = nm;
            exp_q.push_back(x);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset values while rst_n is low
        #7;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_res", 64'(rsp_res), 64'd0);
        chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        issue("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);
        issue("sub_borrow", 3'd1, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1);
        issue("sub_plain", 3'd1, 32'h5, 32'h3, 32'h0000_0002, 1'b0, 1'b0, 1);
        issue("sra4", 3'd4, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 5);
        issue("srl4", 3'd2, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1'b0, 5);
        issue("sll31", 3'd3, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
        issue("sra0", 3'd4, 32'h8000_0010, 32'd0, 32'h8000_0010, 1'b0, 1'b0, 1);
        issue("sll0", 3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 1);
        // Only op2[4:0] is the amount: 0x24 shifts by 4
        issue("srl_hi_bits", 3'd2, 32'h0000_00F0, 32'h0000_0024, 32'h0000_000F, 1'b0, 1'b0, 5);
        issue("illegal6", 3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1);
        issue("add_2p2", 3'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);
        issue("illegal7", 3'd7, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1);
        issue("xor", 3'd5, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b0, 1'b0, 1);
        drain();

        // Backpressure: hold the response for 10 cycles while req_* churns
        rsp_ready = 1'b0;
        issue("bp_xor", 3'd5, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0, 1'b0, 1);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_cmd   = 3'($urandom_range(0, 5));
            req_op1   = $urandom;
            req_op2   = $urandom;
            chk("bp_res", 64'(rsp_res), 64'hEDCB_5678);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(rsp_valid), 64'd0);
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_release_ready", 64'(req_ready), 64'd1);

        // Reset during the 3rd EXEC cycle of SLL by 20 aborts with no response
        issue("sll20_abort", 3'd3, 32'h1, 32'd20, 32'h0010_0000, 1'b0, 1'b0, 21);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_abort_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(rsp_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue("xor_after_rst", 3'd5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 1);
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mas_alu_seq_exec.md
MAS_ALU_SEQ_EXEC -- requirements
Module: mas_alu_seq_exec

Interface
REQ-001 Parameter BLEN, default 32, operand/result width in bits; legal values are powers of two, 8 to 64.
REQ-002 Derived localparam SHW = $clog2(BLEN), shift-amount width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  command/operands present.
REQ-006 req_ready  output  1  block can accept a command.
REQ-007 req_cmd  input  3  opcode: 0 ADD, 1 SUB, 2 SRL, 3 SLL, 4 SRA, 5 XOR; 6 and 7 are illegal.
REQ-008 req_op1  input  BLEN  operand 1.
REQ-009 req_op2  input  BLEN  operand 2; shift amount = req_op2[SHW-1:0].
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer takes the result.
REQ-012 rsp_res  output  BLEN  result.
REQ-013 rsp_carry  output  1  ADD carry-out, or SUB borrow; 0 for all other opcodes.
REQ-014 rsp_err  output  1  illegal opcode flag, qualified by rsp_valid.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and DONE, encoded exclusively.
REQ-017 req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in DONE.
REQ-018 Accept SHALL occur when req_valid && req_ready at a rising edge.
- On accept: capture cmd, op1, op2 into internal registers.
- Load count = op2[SHW-1:0] for opcodes 2 to 4, otherwise count = 0.
- Go to EXEC.
REQ-019 Request inputs SHALL be ignored outside IDLE; later input changes SHALL NOT affect an in-flight operation.
REQ-020 EXEC with count == 0 SHALL finalise the result, load the rsp_* registers and go to DONE on the next edge.
REQ-021 EXEC with count != 0 SHALL shift the working register by one bit per cycle and decrement count.
- SRL: zero fill.
- SLL: zero fill.
- SRA: sign fill from the MSB.
REQ-022 Latency from the accept edge k to rsp_valid rising SHALL be 1 + amount edges for shifts, and 1 edge for all other opcodes.
- Shift amount 0 returns op1 unchanged with 1-edge latency.
REQ-023 ADD SHALL compute rsp_res = (op1 + op2) mod 2^BLEN, with rsp_carry = bit BLEN of the (BLEN+1)-bit sum.
REQ-024 SUB SHALL compute rsp_res = (op1 - op2) mod 2^BLEN, with rsp_carry = 1 iff op1 < op2 unsigned.
REQ-025 XOR SHALL compute rsp_res = op1 ^ op2, with rsp_carry = 0.
REQ-026 An illegal opcode SHALL set rsp_err = 1, rsp_res = 0 and rsp_carry = 0, with 1-edge latency; no other side effect.
REQ-027 rsp_err SHALL be 0 for all legal opcodes.
REQ-028 In DONE, rsp_res, rsp_carry and rsp_err SHALL hold stable until rsp_ready is sampled high; the block then returns to IDLE.
REQ-029 There SHALL be no accept in the same cycle as the DONE to IDLE transition.
- Minimum issue interval is therefore 3 cycles for non-shift opcodes.
REQ-030 When rsp_ready is already high at DONE entry, rsp_valid SHALL last exactly one cycle.
REQ-031 rsp_res, rsp_carry and rsp_err SHALL be registered outputs, with no combinational path from any req_* input.

Reset
REQ-032 When rst_n is low, regardless of clk, the block SHALL take these reset values:
- state = IDLE
- count = 0
- captured operands = 0
- rsp_valid = 0
- rsp_res = 0
- rsp_carry = 0
- rsp_err = 0
- busy = 0
- req_ready = 0 while rst_n is low, and 1 from the first cycle after deassertion.
REQ-033 Reset asserted during EXEC or DONE SHALL abort the operation with no response.
- The first command after deassertion SHALL execute normally.
REQ-034 An X on req_cmd at an accept edge SHALL be flagged by a simulation-only assertion.
REQ-035 A simulation-only assertion SHALL check that rsp_valid && !rsp_ready implies stable rsp_* at the next edge.

Verification
REQ-036 BLEN=32, ADD 0xFFFFFFFF + 0x00000001, rsp_ready=1 -> one edge after accept: rsp_res=0x00000000, rsp_carry=1, rsp_err=0.
REQ-037 SUB 0x00000003 - 0x00000005 -> rsp_res=0xFFFFFFFE, rsp_carry=1; SUB 5 - 3 -> rsp_res=0x00000002, rsp_carry=0.
REQ-038 Shifts, each checked for latency and result:
- SRA op1=0x80000010, op2=4 -> 5 edges, rsp_res=0xF8000001.
- SRL with the same operands -> rsp_res=0x08000001.
- SLL op1=0x1, op2=31 -> 32 edges, rsp_res=0x80000000.
- Any shift with op2=0 -> 1 edge, rsp_res=op1.
REQ-039 cmd=6 with any operands -> rsp_valid, rsp_err=1, rsp_res=0; the next ADD 2+2 returns 4 with rsp_err=0.
REQ-040 Backpressure: hold rsp_ready=0 for 10 cycles in DONE while toggling req_* inputs.
- Required: rsp_* stable, req_ready=0, busy=1 throughout.
- Release rsp_ready -> IDLE next edge, and no extra accept.
REQ-041 Assert rst_n low in the 3rd EXEC cycle of an SLL by 20 -> rsp_valid=0 and busy=0 immediately; the next XOR 0xA5A5A5A5 ^ 0xFFFFFFFF returns 0x5A5A5A5A.
